sysid_check_master: RTL and testbench



---
 rtl/sysid_check_pkg.sv | 28 ++
 rtl/sysid_check_timeout.sv | 41 ++++
 rtl/sysid_check_master.sv | 168 ++++++++++++++++
 tb/tb_sysid_check_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_check_pkg.sv
// rtl/sysid_check_pkg.sv - shared types and constants for the sysid check master
//
// Purpose: FSM state encoding, Avalon word addresses and widths shared by
//          sysid_check_master and sysid_check_timeout.
// Ports:   none (package).
package sysid_check_pkg;

  localparam int SYSID_WORD_W = 32;
  localparam int SYSID_TMO_W  = 16;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_WT_ID,
    ST_RD_TS,
    ST_WT_TS,
    ST_FIN
  } sysid_state_t;

  // True while a read is outstanding (command phase or data wait).
  function automatic logic in_read_window(sysid_state_t s);
    return (s == ST_RD_ID) || (s == ST_WT_ID) || (s == ST_RD_TS) || (s == ST_WT_TS);
  endfunction

endpackage

// File: rtl/sysid_check_timeout.sv
// rtl/sysid_check_timeout.sv - per-read cycle counter for the sysid check master
//
// Purpose: counts cycles spent on one read (command + data wait) and flags
//          the last permitted cycle. Only built with SYSID_CHECK_TIMEOUT_EN.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   clear    in   restart the count (next cycle starts at 0)
//   run      in   a read is outstanding this cycle
//   expired  out  this cycle is the TIMEOUT_CYCLES-th cycle of the read
module sysid_check_timeout
  import sysid_check_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  // count holds the number of completed cycles of the current read, so the
  // cycle in which count == TIMEOUT_CYCLES-1 is the last one allowed.
  localparam logic [SYSID_TMO_W-1:0] LAST = SYSID_TMO_W'(TIMEOUT_CYCLES - 1);

  logic [SYSID_TMO_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count >= LAST);

endmodule

// File: rtl/sysid_check_master.sv
// rtl/sysid_check_master.sv - Avalon-MM master that reads and checks system ID and timestamp
//
// Purpose: on start, reads slave word 0 (ID) and word 1 (timestamp), compares
//          them with EXPECTED_ID / EXPECTED_TS and reports a sticky result.
//          Optional macro SYSID_CHECK_TIMEOUT_EN adds a per-read timeout of
//          TIMEOUT_CYCLES cycles; without it the FSM waits indefinitely.
// Ports:
//   clock, reset                    rising-edge clock, async active-high reset
//   start                           one-cycle request (ignored while busy)
//   avm_address/avm_read            Avalon-MM command outputs
//   avm_waitrequest                 slave stall
//   avm_readdata/avm_readdatavalid  Avalon-MM read response
//   busy                            sequence in progress
//   done                            one-cycle end-of-sequence pulse
//   pass, id_mismatch, ts_mismatch  sticky result flags
//   timeout                         sticky read-timeout flag (0 without macro)
//   id_value, ts_value              last captured words
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [SYSID_WORD_W-1:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [SYSID_WORD_W-1:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int                      TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [SYSID_WORD_W-1:0] avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_mismatch,
  output logic                    ts_mismatch,
  output logic                    timeout,
  output logic [SYSID_WORD_W-1:0] id_value,
  output logic [SYSID_WORD_W-1:0] ts_value
);

  sysid_state_t state;

  logic accept;
  logic data_ok;
  logic expired;
  logic tmo_hit;

  assign accept = avm_read && !avm_waitrequest;

  // Data counts in a WT state, or in an RD state when the command is accepted
  // in the same cycle (zero-latency slave). Anything else is ignored.
  assign data_ok = avm_readdatavalid &&
                   (((state == ST_RD_ID) || (state == ST_RD_TS)) ? accept :
                    ((state == ST_WT_ID) || (state == ST_WT_TS)));

  // Data arriving on the last permitted cycle wins over the timeout.
  assign tmo_hit = expired && !data_ok;

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic clear_cnt;

  // Restart the count whenever the next state is a fresh RD state.
  assign clear_cnt = (state == ST_IDLE) ||
                     (((state == ST_RD_ID) || (state == ST_WT_ID)) && data_ok);

  sysid_check_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear_cnt),
    .run     (in_read_window(state)),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      timeout <= 1'b0;
    end else if (tmo_hit) begin
      timeout <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_RD_ID;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
          end
        end
        ST_RD_ID, ST_WT_ID: begin
          if (data_ok) begin
            id_value    <= avm_readdata;
            id_mismatch <= (avm_readdata != EXPECTED_ID);
            state       <= ST_RD_TS;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_TS;
          end else if (tmo_hit) begin
            state    <= ST_FIN;
            avm_read <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
          end else if ((state == ST_RD_ID) && accept) begin
            state    <= ST_WT_ID;
            avm_read <= 1'b0;
          end
        end
        ST_RD_TS, ST_WT_TS: begin
          if (data_ok) begin
            ts_value    <= avm_readdata;
            ts_mismatch <= (avm_readdata != EXPECTED_TS);
            state       <= ST_FIN;
            avm_read    <= 1'b0;
            done        <= 1'b1;
            // Result is registered together with done so it is valid with the
            // pulse; timeout cannot be set here since it would have ended the run.
            pass        <= !id_mismatch && (avm_readdata == EXPECTED_TS);
          end else if (tmo_hit) begin
            state    <= ST_FIN;
            avm_read <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
          end else if ((state == ST_RD_TS) && accept) begin
            state    <= ST_WT_TS;
            avm_read <= 1'b0;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          avm_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// tb/tb_sysid_check_master.sv - self-checking bench for sysid_check_master
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h5B5A_1C49;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_address, avm_read, busy, done, pass;
  logic        id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sysid_check_master #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy),
    .done(done),
    .pass(pass),
    .id_mismatch(id_mismatch),
    .ts_mismatch(ts_mismatch),
    .timeout(timeout),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  // Runs one sequence against a slave model. lat: 0 = data with acceptance,
  // 1 = data one cycle later, -1 = never. Start goes high in cycle 0; cycle k
  // is sampled at the k-th following falling edge.
  task automatic run_check(input logic [31:0] id_w, input logic [31:0] ts_w,
                           input int stall, input int lat, input int budget,
                           input int extra_a, input int extra_b,
                           output int done_at, output int done_cnt, output int stall_bad);
    int   stall_left;
    bit   pend;
    logic pend_addr;
    bit   prev_wait;
    logic prev_addr;
    done_at = -1; done_cnt = 0; stall_bad = 0;
    stall_left = stall; pend = 0; pend_addr = 1'b0; prev_wait = 0; prev_addr = 1'b0;
    @(negedge clock);
    start = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      start = (k == extra_a) || (k == extra_b);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (prev_wait && ((avm_read !== 1'b1) || (avm_address !== prev_addr))) stall_bad++;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
      if (pend) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = pend_addr ? ts_w : id_w;
        pend = 0;
      end
      if (avm_read === 1'b1) begin
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          stall_left = stall;
          if (lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = avm_address ? ts_w : id_w;
          end else if (lat == 1) begin
            pend = 1;
            pend_addr = avm_address;
          end
        end
      end
      prev_wait = avm_waitrequest;
      prev_addr = avm_address;
    end
    start = 1'b0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, avm_read, avm_address, pass, id_mismatch, ts_mismatch, timeout} !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {busy, done, avm_read, avm_address, pass, id_mismatch, ts_mismatch, timeout});
    end
    checks++;
    if (id_value !== 32'h0) begin
      failures++; $display("FAIL reset_id_value: got %h expected 00000000", id_value);
    end
    checks++;
    if (ts_value !== 32'h0) begin
      failures++; $display("FAIL reset_ts_value: got %h expected 00000000", ts_value);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_match;
    int da, dc, sb;
    run_check(EXP_ID, EXP_TS, 0, 0, 8, 0, 0, da, dc, sb);
    checks++;
    if (da !== 3) begin failures++; $display("FAIL match_done_cycle: got %0d expected 3", da); end
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL match_done_count: got %0d expected 1", dc); end
    checks++;
    if (pass !== 1'b1) begin failures++; $display("FAIL match_pass: got %b expected 1", pass); end
    checks++;
    if ({id_mismatch, ts_mismatch} !== 2'b00) begin
      failures++; $display("FAIL match_mismatch: got %b expected 00", {id_mismatch, ts_mismatch});
    end
    checks++;
    if (ts_value !== EXP_TS) begin
      failures++; $display("FAIL match_ts_value: got %h expected %h", ts_value, EXP_TS);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL match_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_wrong_id;
    int da, dc, sb;
    run_check(32'h0000_0001, EXP_TS, 0, 0, 8, 0, 0, da, dc, sb);
    checks++;
    if (da !== 3) begin failures++; $display("FAIL wrong_id_done_cycle: got %0d expected 3", da); end
    checks++;
    if ({id_mismatch, ts_mismatch, pass} !== 3'b100) begin
      failures++; $display("FAIL wrong_id_flags: got %b expected 100", {id_mismatch, ts_mismatch, pass});
    end
    checks++;
    if (id_value !== 32'h0000_0001) begin
      failures++; $display("FAIL wrong_id_value: got %h expected 00000001", id_value);
    end
  endtask

  task automatic test_stall;
    int da, dc, sb;
    run_check(EXP_ID, EXP_TS, 5, 0, 18, 0, 0, da, dc, sb);
    checks++;
    if (da !== 13) begin failures++; $display("FAIL stall_done_cycle: got %0d expected 13", da); end
    checks++;
    if (sb !== 0) begin failures++; $display("FAIL stall_cmd_stable: got %0d unstable cycles expected 0", sb); end
    checks++;
    if (pass !== 1'b1) begin failures++; $display("FAIL stall_pass: got %b expected 1", pass); end
  endtask

  task automatic test_latency;
    int da, dc, sb;
    run_check(EXP_ID, 32'h1234_5678, 0, 1, 10, 0, 0, da, dc, sb);
    checks++;
    if (da !== 5) begin failures++; $display("FAIL latency_done_cycle: got %0d expected 5", da); end
    checks++;
    if ({id_mismatch, ts_mismatch, pass} !== 3'b010) begin
      failures++; $display("FAIL latency_flags: got %b expected 010", {id_mismatch, ts_mismatch, pass});
    end
    checks++;
    if (ts_value !== 32'h1234_5678) begin
      failures++; $display("FAIL latency_ts_value: got %h expected 12345678", ts_value);
    end
  endtask

  task automatic test_back_to_back;
    int da, dc, sb;
    run_check(EXP_ID, EXP_TS, 0, 0, 10, 2, 3, da, dc, sb);
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL b2b_done_count: got %0d expected 1", dc); end
    checks++;
    if (da !== 3) begin failures++; $display("FAIL b2b_done_cycle: got %0d expected 3", da); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    int dc, da, sb, dc2;
    dc = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = 32'h0000_0001;
    @(negedge clock);
    if (done === 1'b1) dc++;
    avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    @(negedge clock);
    if (done === 1'b1) dc++;
    checks++;
    if ({busy, avm_read, avm_address, id_value} !== {3'b101, 32'h0000_0001}) begin
      failures++; $display("FAIL mid_in_wt_ts: got %b/%h expected 101/00000001",
                           {busy, avm_read, avm_address}, id_value);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_async_reset: got busy=%b expected 0", busy); end
    @(posedge clock);
    #1;
    checks++;
    if ({busy, done, avm_read, avm_address, pass, id_mismatch, ts_mismatch, timeout, id_value, ts_value}
        !== 72'h0) begin
      failures++; $display("FAIL mid_reset_outputs: got %b %h %h expected all zero",
                           {busy, done, avm_read, avm_address, pass, id_mismatch, ts_mismatch, timeout},
                           id_value, ts_value);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done === 1'b1) dc++;
    end
    checks++;
    if (dc !== 0) begin failures++; $display("FAIL mid_no_done: got %0d pulses expected 0", dc); end
    run_check(EXP_ID, EXP_TS, 0, 0, 8, 0, 0, da, dc2, sb);
    checks++;
    if ({da, dc2, 31'd0, pass} !== {32'd3, 32'd1, 31'd0, 1'b1}) begin
      failures++; $display("FAIL mid_restart: got done_at=%0d count=%0d pass=%b expected 3 1 1", da, dc2, pass);
    end
  endtask

  task automatic test_timeout;
    int da, dc, sb;
`ifdef SYSID_CHECK_TIMEOUT_EN
    run_check(EXP_ID, EXP_TS, 0, -1, 14, 0, 0, da, dc, sb);
    checks++;
    if (da !== 9) begin failures++; $display("FAIL timeout_done_cycle: got %0d expected 9", da); end
    checks++;
    if ({timeout, pass} !== 2'b10) begin
      failures++; $display("FAIL timeout_flags: got %b expected 10", {timeout, pass});
    end
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL timeout_done_count: got %0d expected 1", dc); end
`else
    run_check(EXP_ID, EXP_TS, 0, -1, 30, 0, 0, da, dc, sb);
    checks++;
    if (dc !== 0) begin failures++; $display("FAIL wait_forever_done: got %0d expected 0", dc); end
    checks++;
    if ({busy, timeout} !== 2'b10) begin
      failures++; $display("FAIL wait_forever_state: got %b expected 10", {busy, timeout});
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
`endif
  endtask

  initial begin
    test_reset;
    test_match;
    test_wrong_id;
    test_stall;
    test_latency;
    test_back_to_back;
    test_reset_mid;
    test_timeout;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
